// File: rtl/wb_interconnect_arb_nxn.sv
// Registered-arbitration Wishbone N x M interconnect.
//
// Connects N_INITIATORS classic-cycle Wishbone initiators to N_TARGETS
// targets. Each target owns an arbiter (fixed priority or round-robin).
// The arbiter locks its grant for the whole cyc period of the winning
// initiator. Unmatched strobes are answered by a built-in decode-error
// responder. An optional per-target watchdog ends stalled cycles with err.
//
// Ports (initiator signals packed per initiator j, target signals packed
// per target i):
//   clk, rst                            clock, synchronous active-low reset
//   adr, dat_w, cyc, stb, we, sel       initiator requests (in)
//   dat_r, ack, err                     initiator responses (out)
//   tadr, tdat_w, tcyc, tstb, twe, tsel target requests (out)
//   tdat_r, tack, terr                  target responses (in)
module wb_interconnect_arb_nxn #(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned N_INITIATORS   = 2,
    parameter int unsigned N_TARGETS      = 2,
    parameter logic [WB_ADDR_WIDTH*N_TARGETS-1:0] T_ADR      = {32'h2000_0000, 32'h1000_0000},
    parameter logic [WB_ADDR_WIDTH*N_TARGETS-1:0] T_ADR_MASK = {32'hF000_0000, 32'hF000_0000},
    parameter int unsigned ARB_MODE       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [N_INITIATORS*WB_ADDR_WIDTH-1:0]       adr,
    input  logic [N_INITIATORS*WB_DATA_WIDTH-1:0]       dat_w,
    output logic [N_INITIATORS*WB_DATA_WIDTH-1:0]       dat_r,
    input  logic [N_INITIATORS-1:0]                     cyc,
    input  logic [N_INITIATORS-1:0]                     stb,
    input  logic [N_INITIATORS-1:0]                     we,
    input  logic [N_INITIATORS*(WB_DATA_WIDTH/8)-1:0]   sel,
    output logic [N_INITIATORS-1:0]                     ack,
    output logic [N_INITIATORS-1:0]                     err,
    output logic [N_TARGETS*WB_ADDR_WIDTH-1:0]          tadr,
    output logic [N_TARGETS*WB_DATA_WIDTH-1:0]          tdat_w,
    output logic [N_TARGETS-1:0]                        tcyc,
    output logic [N_TARGETS-1:0]                        tstb,
    output logic [N_TARGETS-1:0]                        twe,
    output logic [N_TARGETS*(WB_DATA_WIDTH/8)-1:0]      tsel,
    input  logic [N_TARGETS*WB_DATA_WIDTH-1:0]          tdat_r,
    input  logic [N_TARGETS-1:0]                        tack,
    input  logic [N_TARGETS-1:0]                        terr
);

    localparam int unsigned AW   = WB_ADDR_WIDTH;
    localparam int unsigned DW   = WB_DATA_WIDTH;
    localparam int unsigned SW   = WB_DATA_WIDTH / 8;
    localparam int unsigned NI   = N_INITIATORS;
    localparam int unsigned NT   = N_TARGETS;
    localparam int unsigned ID_W = (NI > 1) ? $clog2(NI) : 1;
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [NI*NT-1:0]   hit;      // hit[j*NT+i]: initiator j decodes to target i
    logic [NI-1:0]      any_hit;
    logic [NI-1:0]      derr_q;
    logic [NT-1:0]      busy_vec;
    logic [NT*ID_W-1:0] gnt_vec;
    logic [NT-1:0]      wd_err;

    // Address decode; on overlapping ranges the lowest target index wins,
    // so each initiator hits at most one target.
    always_comb begin
        hit     = '0;
        any_hit = '0;
        for (int unsigned j = 0; j < NI; j++) begin
            for (int unsigned i = 0; i < NT; i++) begin
                if (!any_hit[j] &&
                    ((adr[j*AW +: AW] & T_ADR_MASK[i*AW +: AW]) == T_ADR[i*AW +: AW])) begin
                    hit[j*NT + i] = 1'b1;
                    any_hit[j]    = 1'b1;
                end
            end
        end
    end

    // Decode-error responder: the ~derr_q term makes a held strobe see err
    // every second cycle.
    always_ff @(posedge clk) begin
        if (!rst) derr_q <= '0;
        else      derr_q <= cyc & stb & ~any_hit & ~derr_q;
    end

    for (genvar gi = 0; gi < NT; gi++) begin : g_tgt
        state_t          state_q, state_d;
        logic [ID_W-1:0] gnt_q, gnt_d, last_q, last_d, winner;
        logic [NI-1:0]   req;
        logic            won;
        logic [AW-1:0]   g_adr;
        logic [DW-1:0]   g_dat;
        logic [SW-1:0]   g_sel;
        logic            g_we, g_cyc, g_stb, g_hit;
        logic            busy, t_stb;

        always_comb begin
            req = '0;
            for (int unsigned j = 0; j < NI; j++) begin
                req[j] = cyc[j] & stb[j] & hit[j*NT + gi];
            end
        end

        // Round-robin scans the indices above last_q first, then wraps to
        // the bottom; that is the same as a modulo scan from last_q+1.
        always_comb begin
            winner = '0;
            won    = 1'b0;
            if (ARB_MODE == 0) begin
                for (int unsigned j = 0; j < NI; j++) begin
                    if (!won && req[j]) begin
                        winner = ID_W'(j);
                        won    = 1'b1;
                    end
                end
            end else begin
                for (int unsigned j = 0; j < NI; j++) begin
                    if (!won && req[j] && (ID_W'(j) > last_q)) begin
                        winner = ID_W'(j);
                        won    = 1'b1;
                    end
                end
                for (int unsigned j = 0; j < NI; j++) begin
                    if (!won && req[j]) begin
                        winner = ID_W'(j);
                        won    = 1'b1;
                    end
                end
            end
        end

        // Select the signals of the granted initiator.
        always_comb begin
            g_adr = '0;
            g_dat = '0;
            g_sel = '0;
            g_we  = 1'b0;
            g_cyc = 1'b0;
            g_stb = 1'b0;
            g_hit = 1'b0;
            for (int unsigned j = 0; j < NI; j++) begin
                if (gnt_q == ID_W'(j)) begin
                    g_adr = adr[j*AW +: AW];
                    g_dat = dat_w[j*DW +: DW];
                    g_sel = sel[j*SW +: SW];
                    g_we  = we[j];
                    g_cyc = cyc[j];
                    g_stb = stb[j];
                    g_hit = hit[j*NT + gi];
                end
            end
        end

        always_comb begin
            state_d = state_q;
            gnt_d   = gnt_q;
            last_d  = last_q;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_d = BUSY;
                        gnt_d   = winner;
                        last_d  = winner;
                    end
                end
                BUSY: begin
                    if (!g_cyc) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q <= IDLE;
                gnt_q   <= '0;
                last_q  <= ID_W'(NI - 1);
            end else begin
                state_q <= state_d;
                gnt_q   <= gnt_d;
                last_q  <= last_d;
            end
        end

        assign busy  = (state_q == BUSY);
        // Strobe is forwarded only while the locked owner still decodes here.
        assign t_stb = busy & g_stb & g_hit;

        assign tadr[gi*AW +: AW]   = busy ? g_adr : '0;
        assign tdat_w[gi*DW +: DW] = busy ? g_dat : '0;
        assign tsel[gi*SW +: SW]   = busy ? g_sel : '0;
        assign twe[gi]             = busy & g_we;
        assign tcyc[gi]            = busy & g_cyc;
        assign tstb[gi]            = t_stb;

        assign busy_vec[gi]             = busy;
        assign gnt_vec[gi*ID_W +: ID_W] = gnt_q;

        if (TIMEOUT_CYCLES > 0) begin : g_wd
            logic [WD_W-1:0] wd_cnt;

            assign wd_err[gi] = (wd_cnt == WD_W'(TIMEOUT_CYCLES)) & t_stb;

            always_ff @(posedge clk) begin
                if (!rst || !busy || !g_cyc || !t_stb || tack[gi] || terr[gi] || wd_err[gi])
                    wd_cnt <= '0;
                else
                    wd_cnt <= wd_cnt + WD_W'(1);
            end
        end else begin : g_no_wd
            assign wd_err[gi] = 1'b0;
        end
    end

    // Return path: an initiator gets responses only from targets that
    // currently grant it.
    always_comb begin
        dat_r = '0;
        ack   = '0;
        err   = '0;
        for (int unsigned j = 0; j < NI; j++) begin
            for (int unsigned i = 0; i < NT; i++) begin
                if (busy_vec[i] && (gnt_vec[i*ID_W +: ID_W] == ID_W'(j))) begin
                    dat_r[j*DW +: DW] = dat_r[j*DW +: DW] | tdat_r[i*DW +: DW];
                    ack[j]            = ack[j] | tack[i];
                    err[j]            = err[j] | terr[i] | wd_err[i];
                end
            end
            err[j] = err[j] | derr_q[j];
        end
    end

endmodule

// File: tb/tb_wb_interconnect_arb_nxn.sv
// Directed self-checking bench for wb_interconnect_arb_nxn.
// Three instances share one set of initiator inputs: round-robin,
// fixed-priority, and round-robin with a 4-cycle watchdog. Each test
// resets all of them and checks one instance. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_wb_interconnect_arb_nxn;

    logic        clk;
    logic        rst;
    logic [63:0] adr, dat_w;
    logic [1:0]  cyc, stb, we;
    logic [7:0]  sel;

    localparam logic [63:0] TDAT = {32'hCAFE_0001, 32'hDEAD_BEEF};

    logic [63:0] dat_r_rr, tadr_rr, tdat_w_rr;
    logic [1:0]  ack_rr, err_rr, tcyc_rr, tstb_rr, twe_rr, tack_rr;
    logic [7:0]  tsel_rr;
    logic [63:0] dat_r_fp, tadr_fp, tdat_w_fp;
    logic [1:0]  ack_fp, err_fp, tcyc_fp, tstb_fp, twe_fp, tack_fp;
    logic [7:0]  tsel_fp;
    logic [63:0] dat_r_wd, tadr_wd, tdat_w_wd;
    logic [1:0]  ack_wd, err_wd, tcyc_wd, tstb_wd, twe_wd;
    logic [7:0]  tsel_wd;

    int n_chk;
    int n_fail;

    wb_interconnect_arb_nxn #(.ARB_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .adr(adr), .dat_w(dat_w), .dat_r(dat_r_rr),
        .cyc(cyc), .stb(stb), .we(we), .sel(sel), .ack(ack_rr), .err(err_rr),
        .tadr(tadr_rr), .tdat_w(tdat_w_rr), .tcyc(tcyc_rr), .tstb(tstb_rr),
        .twe(twe_rr), .tsel(tsel_rr), .tdat_r(TDAT), .tack(tack_rr), .terr(2'b00)
    );

    wb_interconnect_arb_nxn #(.ARB_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .adr(adr), .dat_w(dat_w), .dat_r(dat_r_fp),
        .cyc(cyc), .stb(stb), .we(we), .sel(sel), .ack(ack_fp), .err(err_fp),
        .tadr(tadr_fp), .tdat_w(tdat_w_fp), .tcyc(tcyc_fp), .tstb(tstb_fp),
        .twe(twe_fp), .tsel(tsel_fp), .tdat_r(TDAT), .tack(tack_fp), .terr(2'b00)
    );

    wb_interconnect_arb_nxn #(.ARB_MODE(1), .TIMEOUT_CYCLES(4)) dut_wd (
        .clk(clk), .rst(rst), .adr(adr), .dat_w(dat_w), .dat_r(dat_r_wd),
        .cyc(cyc), .stb(stb), .we(we), .sel(sel), .ack(ack_wd), .err(err_wd),
        .tadr(tadr_wd), .tdat_w(tdat_w_wd), .tcyc(tcyc_wd), .tstb(tstb_wd),
        .twe(twe_wd), .tsel(tsel_wd), .tdat_r(TDAT), .tack(2'b00), .terr(2'b00)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Targets that ack one cycle after seeing a strobe, for one cycle.
    always @(posedge clk) begin
        if (!rst) begin
            tack_rr <= '0;
            tack_fp <= '0;
        end else begin
            tack_rr <= tstb_rr & ~tack_rr;
            tack_fp <= tstb_fp & ~tack_fp;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        adr   = '0;
        dat_w = '0;
        cyc   = '0;
        stb   = '0;
        we    = '0;
        sel   = '0;
    endtask

    task automatic do_reset;
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Both initiators do 4 single cycles each to 0x2000_0000, dropping cyc
    // for one cycle after every ack.
    task automatic run_contention(input bit rr);
        int   done [2];
        bit   drop [2];
        logic [1:0] a;
        logic       tc;
        int   ph, own;
        done[0] = 0; done[1] = 0;
        drop[0] = 1'b0; drop[1] = 1'b0;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            tick();
            for (int j = 0; j < 2; j++) begin
                cyc[j] = (done[j] < 4) && !drop[j];
                stb[j] = cyc[j];
                adr[j*32 +: 32] = 32'h2000_0000;
            end
            @(negedge clk);
            a   = rr ? ack_rr : ack_fp;
            tc  = rr ? tcyc_rr[1] : tcyc_fp[1];
            ph  = c % 4;
            own = rr ? ((c / 4) % 2) : ((c / 4 < 4) ? 0 : 1);
            chk($sformatf("%s_tcyc1 c%0d", rr ? "rr" : "fp", c), 64'(tc), 64'(ph == 1 || ph == 2));
            chk($sformatf("%s_ack0 c%0d", rr ? "rr" : "fp", c), 64'(a[0]), 64'(ph == 2 && own == 0));
            chk($sformatf("%s_ack1 c%0d", rr ? "rr" : "fp", c), 64'(a[1]), 64'(ph == 2 && own == 1));
            for (int j = 0; j < 2; j++) begin
                drop[j] = a[j];
                if (a[j]) done[j]++;
            end
        end
        chk(rr ? "rr_done0" : "fp_done0", 64'(done[0]), 64'd4);
        chk(rr ? "rr_done1" : "fp_done1", 64'(done[1]), 64'd4);
    endtask

    initial begin
        int   acks0, acks1;
        bit   drop0;
        logic [13:0] lock_mask;

        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        idle_inputs();

        // Reset state of all instances
        do_reset();
        tick();
        @(negedge clk);
        chk("rst_rr_tadr", tadr_rr, '0);
        chk("rst_rr_tdatw", tdat_w_rr, '0);
        chk("rst_rr_datr", dat_r_rr, '0);
        chk("rst_rr_ctl", 64'({ack_rr, err_rr, tcyc_rr, tstb_rr, twe_rr, tsel_rr}), '0);
        chk("rst_fp_tadr", tadr_fp, '0);
        chk("rst_fp_tdatw", tdat_w_fp, '0);
        chk("rst_fp_datr", dat_r_fp, '0);
        chk("rst_fp_ctl", 64'({ack_fp, err_fp, tcyc_fp, tstb_fp, twe_fp, tsel_fp}), '0);
        chk("rst_wd_tadr", tadr_wd, '0);
        chk("rst_wd_tdatw", tdat_w_wd, '0);
        chk("rst_wd_datr", dat_r_wd, '0);
        chk("rst_wd_ctl", 64'({ack_wd, err_wd, tcyc_wd, tstb_wd, twe_wd, tsel_wd}), '0);

        // Single read by initiator 0 of 0x1000_0010 (target 0)
        do_reset();
        for (int c = 0; c < 5; c++) begin
            tick();
            cyc[0] = (c <= 2);
            stb[0] = (c <= 2);
            adr[31:0] = 32'h1000_0010;
            @(negedge clk);
            chk($sformatf("single_tstb0 c%0d", c), 64'(tstb_rr[0]), 64'(c == 1 || c == 2));
            chk($sformatf("single_ack0 c%0d", c), 64'(ack_rr[0]), 64'(c == 2));
            chk($sformatf("single_tcyc1 c%0d", c), 64'(tcyc_rr[1]), 64'd0);
            if (c == 2) chk("single_datr0", 64'(dat_r_rr[31:0]), 64'h0000_0000_DEAD_BEEF);
            if (c == 0) chk("single_datr0_idle", 64'(dat_r_rr[31:0]), 64'd0);
        end

        run_contention(1'b1);
        run_contention(1'b0);

        // Bus lock: initiator 0 keeps cyc for 3 strobes to target 1
        do_reset();
        acks0 = 0;
        acks1 = 0;
        drop0 = 1'b0;
        lock_mask = 14'b01100110110110;
        for (int c = 0; c < 14; c++) begin
            tick();
            cyc[0] = (acks0 < 3);
            stb[0] = (acks0 < 3) && !drop0;
            adr[31:0] = 32'h2000_0004;
            cyc[1] = (acks1 < 1);
            stb[1] = (acks1 < 1);
            adr[63:32] = 32'h2000_0008;
            @(negedge clk);
            chk($sformatf("lock_tstb1 c%0d", c), 64'(tstb_rr[1]), 64'(lock_mask[c]));
            chk($sformatf("lock_ack1 c%0d", c), 64'(ack_rr[1]), 64'(c == 12));
            if (lock_mask[c])
                chk($sformatf("lock_tadr1 c%0d", c), 64'(tadr_rr[63:32]),
                    (c < 10) ? 64'h2000_0004 : 64'h2000_0008);
            drop0 = ack_rr[0];
            if (ack_rr[0]) acks0++;
            if (ack_rr[1]) acks1++;
        end

        // Decode error: initiator 1 holds a strobe to an unmapped address
        do_reset();
        for (int c = 0; c < 6; c++) begin
            tick();
            cyc[1] = 1'b1;
            stb[1] = 1'b1;
            adr[63:32] = 32'h5000_0000;
            @(negedge clk);
            chk($sformatf("derr_err1 c%0d", c), 64'(err_rr[1]), 64'(c % 2 == 1));
            chk($sformatf("derr_ack1 c%0d", c), 64'(ack_rr[1]), 64'd0);
            chk($sformatf("derr_tcyc c%0d", c), 64'(tcyc_rr), 64'd0);
            chk($sformatf("derr_tstb c%0d", c), 64'(tstb_rr), 64'd0);
        end

        // Watchdog on a target that never answers, then mid-cycle reset
        do_reset();
        for (int c = 0; c < 7; c++) begin
            tick();
            cyc[0] = 1'b1;
            stb[0] = 1'b1;
            we[0]  = 1'b1;
            sel[3:0] = 4'hF;
            adr[31:0] = 32'h1000_0000;
            dat_w[31:0] = 32'h1234_5678;
            @(negedge clk);
            chk($sformatf("wd_tstb0 c%0d", c), 64'(tstb_wd[0]), 64'(c >= 1));
            chk($sformatf("wd_err0 c%0d", c), 64'(err_wd[0]), 64'(c == 5));
            if (c == 1) begin
                chk("wd_tdatw0", 64'(tdat_w_wd[31:0]), 64'h1234_5678);
                chk("wd_twe0", 64'(twe_wd[0]), 64'd1);
                chk("wd_tsel0", 64'(tsel_wd[3:0]), 64'hF);
            end
        end
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("wdrst_tadr", tadr_wd, '0);
        chk("wdrst_tdatw", tdat_w_wd, '0);
        chk("wdrst_datr", dat_r_wd, '0);
        chk("wdrst_ctl", 64'({ack_wd, err_wd, tcyc_wd, tstb_wd, twe_wd, tsel_wd}), '0);
        rst = 1'b1;
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
